control_unit: RTL

//  Microsequencer for the simple CPU datapath (PC, MAR, MBR, IR, BR, ACC/ALU, memory).

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/cu_decoder.sv | 39 +++
 rtl/control_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU microsequencer and datapath: states, opcodes, control-bit indices.
// CU_SINGLE_STEP_EN adds the PAUSE state used for single-step operation.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_F4,
        S_RD,
        S_BR,
        S_LDA,
        S_ADD,
        S_SUB,
        S_AND,
        S_OR,
        S_STM,
        S_WR,
        S_JMP,
        S_JGEZ,
        S_CLR,
        S_HALT
`ifdef CU_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } cu_state_t;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_AND    = 8'h08;
    localparam logic [7:0] OP_OR     = 8'h09;
    localparam logic [7:0] OP_CLR    = 8'h0A;

    localparam int unsigned CB_PC_INC      = 0;
    localparam int unsigned CB_PC_LOAD     = 1;
    localparam int unsigned CB_PC_TO_MAR   = 2;
    localparam int unsigned CB_MBR_TO_MAR  = 3;
    localparam int unsigned CB_MEM_READ    = 4;
    localparam int unsigned CB_MEM_WRITE   = 5;
    localparam int unsigned CB_MBR_TO_IR   = 6;
    localparam int unsigned CB_MBR_TO_BR   = 7;
    localparam int unsigned CB_ACC_TO_MBR  = 8;
    localparam int unsigned CB_ALU_ADD     = 9;
    localparam int unsigned CB_ALU_SUB     = 10;
    localparam int unsigned CB_ACC_CLR     = 11;
    localparam int unsigned CB_ALU_AND     = 12;
    localparam int unsigned CB_ALU_OR      = 13;
    localparam int unsigned CB_ACC_LOAD_BR = 14;

    function automatic logic is_mem_wait(input cu_state_t s);
        return (s == S_F2) || (s == S_RD) || (s == S_WR);
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational control-word decode from the sequencer state; only PC_LOAD in S_JGEZ looks at acc_neg.
// CU_SINGLE_STEP_EN: the PAUSE state decodes to an all-zero word like IDLE/HALT.
module cu_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W = 16
) (
    input  cu_state_t         i_state,
    input  logic              i_acc_neg,
    output logic [CTRL_W-1:0] o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_F1:    o_ctrl[CB_PC_TO_MAR] = 1'b1;
            S_F2:    o_ctrl[CB_MEM_READ] = 1'b1;
            S_F3: begin
                o_ctrl[CB_MBR_TO_IR] = 1'b1;
                o_ctrl[CB_PC_INC]    = 1'b1;
            end
            S_F4:    o_ctrl[CB_MBR_TO_MAR] = 1'b1;
            S_RD:    o_ctrl[CB_MEM_READ] = 1'b1;
            S_BR:    o_ctrl[CB_MBR_TO_BR] = 1'b1;
            S_LDA:   o_ctrl[CB_ACC_LOAD_BR] = 1'b1;
            S_ADD:   o_ctrl[CB_ALU_ADD] = 1'b1;
            S_SUB:   o_ctrl[CB_ALU_SUB] = 1'b1;
            S_AND:   o_ctrl[CB_ALU_AND] = 1'b1;
            S_OR:    o_ctrl[CB_ALU_OR] = 1'b1;
            S_STM:   o_ctrl[CB_ACC_TO_MBR] = 1'b1;
            S_WR:    o_ctrl[CB_MEM_WRITE] = 1'b1;
            S_JMP:   o_ctrl[CB_PC_LOAD] = 1'b1;
            S_JGEZ:  o_ctrl[CB_PC_LOAD] = ~i_acc_neg;
            S_CLR:   o_ctrl[CB_ACC_CLR] = 1'b1;
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microsequencer: fetch/decode/execute state machine, memory-wait timeout and sticky fault flags.
// CU_SINGLE_STEP_EN: adds the step input and a PAUSE state entered after every instruction.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned OP_W        = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   ir_data,
    input  logic              acc_neg,
    input  logic              mem_ready,
`ifdef CU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [CTRL_W-1:0] control_signals,
    output logic              instr_done,
    output logic              halted,
    output logic              illegal_op,
    output logic              mem_fault
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

`ifdef CU_SINGLE_STEP_EN
    localparam cu_state_t AFTER_DONE = S_PAUSE;
`else
    localparam cu_state_t AFTER_DONE = S_F1;
`endif

    cu_state_t        r_state, w_next;
    cu_state_t        r_exec, w_exec_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal, r_fault;
    logic             w_wait, w_timeout, w_done, w_set_illegal;

    always_comb begin
        w_next        = r_state;
        w_exec_next   = r_exec;
        w_done        = 1'b0;
        w_set_illegal = 1'b0;
        w_wait        = is_mem_wait(r_state);
        w_timeout     = w_wait && !mem_ready && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
        case (r_state)
            S_IDLE: if (start) w_next = S_F1;
            S_F1:   w_next = S_F2;
            S_F2:   if (mem_ready) w_next = S_F3;
            S_F3:   w_next = S_F4;
            // Read-type ops share RD/BR; the final execute state is remembered in r_exec.
            S_F4: begin
                case (ir_data)
                    OP_LOAD:   begin w_next = S_RD; w_exec_next = S_LDA; end
                    OP_ADD:    begin w_next = S_RD; w_exec_next = S_ADD; end
                    OP_SUB:    begin w_next = S_RD; w_exec_next = S_SUB; end
                    OP_AND:    begin w_next = S_RD; w_exec_next = S_AND; end
                    OP_OR:     begin w_next = S_RD; w_exec_next = S_OR;  end
                    OP_STORE:  w_next = S_STM;
                    OP_JMP:    w_next = S_JMP;
                    OP_JMPGEZ: w_next = S_JGEZ;
                    OP_CLR:    w_next = S_CLR;
                    OP_HALT:   w_next = S_HALT;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_RD:   if (mem_ready) w_next = S_BR;
            S_BR:   w_next = r_exec;
            S_STM:  w_next = S_WR;
            S_WR: begin
                if (mem_ready) begin
                    w_done = 1'b1;
                    w_next = AFTER_DONE;
                end
            end
            S_LDA, S_ADD, S_SUB, S_AND, S_OR, S_JMP, S_JGEZ, S_CLR: begin
                w_done = 1'b1;
                w_next = AFTER_DONE;
            end
            S_HALT: w_next = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: if (step) w_next = S_F1;
`endif
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_exec    <= S_IDLE;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_exec  <= w_exec_next;
            // Every wait state is entered from a non-wait state, so clearing outside waits clears on entry.
            r_cnt   <= (w_wait && !mem_ready) ? r_cnt + CNT_W'(1) : '0;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_timeout)     r_fault   <= 1'b1;
        end
    end

    cu_decoder #(
        .CTRL_W (CTRL_W)
    ) u_dec (
        .i_state   (r_state),
        .i_acc_neg (acc_neg),
        .o_ctrl    (control_signals)
    );

    assign instr_done = w_done;
    assign halted     = (r_state == S_HALT);
    assign illegal_op = r_illegal;
    assign mem_fault  = r_fault;

endmodule
